gx_rst_ctrl: RTL and testbench
==============================

Name: gx_rst_ctrl

Overview:
- Transceiver reset sequencer; drives the native PHY reset inputs that the PCS top exposes (tx/rx analogreset, tx/rx digitalreset).
- Consumes PHY status (cal_busy, rx_is_lockedtodata, TX PLL locked) and emits per-direction ready flags to the PCS.
- Runs in the 50 MHz oscillator domain; all PHY status inputs are asynchronous and synchronized internally.

Parameters:
- ANALOG_HOLD_CYC, 3500, minimum cycles analogreset held asserted after reset/recal (70 us @ 50 MHz)
- DIGITAL_WAIT_CYC, 250, cycles TX PLL must stay locked before tx_digitalreset release (5 us)
- LTD_STABLE_CYC, 200, cycles rx_is_lockedtodata must stay continuously high before rx_digitalreset release (4 us)
- SYNC_STAGES, 2, flop depth of input synchronizers (>=2)

Ports:
- clk  in  1  50 MHz clock
- rst  in  1  synchronous active-high reset
- pll_locked_i  in  1  TX fPLL locked, async
- tx_cal_busy_i  in  1  TX calibration in progress, async
- rx_cal_busy_i  in  1  RX calibration in progress, async
- rx_is_lockedtodata_i  in  1  CDR locked to data, async
- tx_analogreset_o  out  1  to PHY
- tx_digitalreset_o  out  1  to PHY
- rx_analogreset_o  out  1  to PHY
- rx_digitalreset_o  out  1  to PHY
- tx_ready_o  out  1  TX path out of reset
- rx_ready_o  out  1  RX path out of reset

Behaviour:
- Clock and reset fixed: single clock clk; rst synchronous, active-high.
- rst=1: TX FSM->TX_ANA, RX FSM->RX_ANA, counters 0; all four reset outputs 1, both ready 0. Synchronizer flops reset: cal_busy chains to 1, pll_locked/lockedtodata chains to 0.
- Synchronized signals (suffix _s) lag the pins by SYNC_STAGES cycles; FSMs see only _s.
- Outputs are pure decodes of the state register: no combinational path from inputs, and outputs change on the same edge as the state.
- Counters clear on every state entry; width $clog2(max(cycle params)+1); saturating.
- TX FSM:
  - TX_ANA (ana=1, dig=1): count; exit to TX_PLL when cnt>=ANALOG_HOLD_CYC-1 and tx_cal_busy_s=0, else stay.
  - TX_PLL (ana=0, dig=1): to TX_DIG on the next edge with pll_locked_s=1.
  - TX_DIG (ana=0, dig=1): count; pll_locked_s=0 -> TX_PLL; cnt==DIGITAL_WAIT_CYC-1 -> TX_RDY.
  - TX_RDY (ana=0, dig=0, tx_ready_o=1): pll_locked_s=0 -> TX_PLL.
  - tx_cal_busy_s=1 in any state except TX_ANA -> TX_ANA; takes priority over PLL loss.
- RX FSM:
  - RX_ANA (ana=1, dig=1): exit to RX_LTD under the same rule as TX_ANA, using rx_cal_busy_s.
  - RX_LTD (ana=0, dig=1): cnt clears whenever lockedtodata_s=0; cnt==LTD_STABLE_CYC-1 with lockedtodata_s=1 -> RX_RDY.
  - RX_RDY (ana=0, dig=0, rx_ready_o=1): lockedtodata_s=0 -> RX_LTD; only digital reasserts, analog stays released.
  - rx_cal_busy_s=1 in any state except RX_ANA -> RX_ANA; takes priority over LTD loss.
- TX and RX FSMs are independent; neither gates the other.
- cal_busy held high forever: analogreset stays asserted indefinitely, no timeout.
- rst asserted mid-sequence: immediate return to the reset values on the next edge.

Decomposition:
- Package gx_rst_pkg: tx_state_e {TX_ANA, TX_PLL, TX_DIG, TX_RDY}, rx_state_e {RX_ANA, RX_LTD, RX_RDY}, counter width function.
- Sub-module gx_sync: SYNC_STAGES-deep flop chain with reset-value parameter; instanced 4 times.

Test Plan:
Bench params: ANALOG_HOLD_CYC=10, DIGITAL_WAIT_CYC=4, LTD_STABLE_CYC=5, SYNC_STAGES=2. Inputs at bench start: cal_busy=0, pll_locked=1, lockedtodata=1.
- Power-up: release rst at edge 0 -> tx_analogreset_o falls at edge 10, tx_digitalreset_o and tx_ready_o change at edge 15; rx_analogreset_o falls at edge 10, rx_digitalreset_o falls at edge 15.
- Calibration stall: tx_cal_busy_i=1 until edge 30 -> tx_analogreset_o stays 1, falls at edge 33 (sync lag plus 1); rx path unaffected.
- PLL loss in TX_RDY: pll_locked_i low 1 cycle -> tx_digitalreset_o=1 and tx_ready_o=0 two edges later, tx_analogreset_o stays 0; tx_ready_o returns 1 five edges after relock is seen.
- CDR glitch during RX_LTD: lockedtodata pulses low at cnt=3 -> counter restarts; rx_ready_o is delayed by the full LTD_STABLE_CYC from the last rise.
- Recal from ready: rx_cal_busy_i=1 while RX_RDY with lockedtodata dropping simultaneously -> goes to RX_ANA (not RX_LTD); both rx resets=1; full 10+5 sequence repeats.
- rst mid-sequence: rst=1 during TX_DIG -> next edge: all resets 1, readies 0, counters 0; sequence restarts from TX_ANA.

Source files
------------

// File: rtl/gx_rst_pkg.sv
// Shared types and sizing helpers for the transceiver reset sequencer.
package gx_rst_pkg;

  typedef enum logic [1:0] {TX_ANA, TX_PLL, TX_DIG, TX_RDY} tx_state_e;
  typedef enum logic [1:0] {RX_ANA, RX_LTD, RX_RDY} rx_state_e;

  // Counter wide enough to reach the largest of the three cycle parameters.
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/gx_sync.sv
// Multi-flop synchronizer for one async status bit, with selectable reset value.
module gx_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q, chain_d;

  always_comb chain_d = {chain_q[STAGES-2:0], d_i};

  always_ff @(posedge clk) begin
    if (rst) chain_q <= {STAGES{RST_VAL}};
    else     chain_q <= chain_d;
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/gx_rst_ctrl.sv
// Transceiver reset sequencer: independent TX and RX FSMs driving PHY analog/digital
// resets from synchronized PLL, calibration and CDR status.
module gx_rst_ctrl
  import gx_rst_pkg::*;
#(
  parameter int unsigned ANALOG_HOLD_CYC  = 3500,
  parameter int unsigned DIGITAL_WAIT_CYC = 250,
  parameter int unsigned LTD_STABLE_CYC   = 200,
  parameter int unsigned SYNC_STAGES      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked_i,
  input  logic tx_cal_busy_i,
  input  logic rx_cal_busy_i,
  input  logic rx_is_lockedtodata_i,
  output logic tx_analogreset_o,
  output logic tx_digitalreset_o,
  output logic rx_analogreset_o,
  output logic rx_digitalreset_o,
  output logic tx_ready_o,
  output logic rx_ready_o
);

  localparam int CW = cnt_w(int'(ANALOG_HOLD_CYC), int'(DIGITAL_WAIT_CYC), int'(LTD_STABLE_CYC));
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] ANA_LAST = CW'(ANALOG_HOLD_CYC - 1);
  localparam logic [CW-1:0] DIG_LAST = CW'(DIGITAL_WAIT_CYC - 1);
  localparam logic [CW-1:0] LTD_LAST = CW'(LTD_STABLE_CYC - 1);

  logic pll_locked_s, tx_cal_busy_s, rx_cal_busy_s, ltd_s;

  // Calibration chains reset busy so nothing leaves analog reset before real status arrives.
  gx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_pll (
    .clk(clk), .rst(rst), .d_i(pll_locked_i), .q_o(pll_locked_s));
  gx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_txcal (
    .clk(clk), .rst(rst), .d_i(tx_cal_busy_i), .q_o(tx_cal_busy_s));
  gx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rxcal (
    .clk(clk), .rst(rst), .d_i(rx_cal_busy_i), .q_o(rx_cal_busy_s));
  gx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ltd (
    .clk(clk), .rst(rst), .d_i(rx_is_lockedtodata_i), .q_o(ltd_s));

  tx_state_e       tx_state_q, tx_state_d;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;

  always_comb begin
    tx_state_d = tx_state_q;
    if (tx_cal_busy_s && tx_state_q != TX_ANA) begin
      tx_state_d = TX_ANA;
    end else begin
      case (tx_state_q)
        TX_ANA: if (tx_cnt_q >= ANA_LAST && !tx_cal_busy_s) tx_state_d = TX_PLL;
        TX_PLL: if (pll_locked_s) tx_state_d = TX_DIG;
        TX_DIG: begin
          if (!pll_locked_s)             tx_state_d = TX_PLL;
          else if (tx_cnt_q == DIG_LAST) tx_state_d = TX_RDY;
        end
        TX_RDY: if (!pll_locked_s) tx_state_d = TX_PLL;
        default: tx_state_d = TX_ANA;
      endcase
    end
    tx_cnt_d = (tx_state_d != tx_state_q) ? '0 : tx_cnt_q + CW'(tx_cnt_q != CNT_MAX);
  end

  always_comb begin
    rx_state_d = rx_state_q;
    if (rx_cal_busy_s && rx_state_q != RX_ANA) begin
      rx_state_d = RX_ANA;
    end else begin
      case (rx_state_q)
        RX_ANA: if (rx_cnt_q >= ANA_LAST && !rx_cal_busy_s) rx_state_d = RX_LTD;
        RX_LTD: if (ltd_s && rx_cnt_q == LTD_LAST) rx_state_d = RX_RDY;
        RX_RDY: if (!ltd_s) rx_state_d = RX_LTD;
        default: rx_state_d = RX_ANA;
      endcase
    end
    // Lock-to-data must be continuously high, so any drop restarts the stability window.
    if (rx_state_d != rx_state_q || (rx_state_q == RX_LTD && !ltd_s))
      rx_cnt_d = '0;
    else
      rx_cnt_d = rx_cnt_q + CW'(rx_cnt_q != CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_ANA;
      rx_state_q <= RX_ANA;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  assign tx_analogreset_o  = (tx_state_q == TX_ANA);
  assign tx_digitalreset_o = (tx_state_q != TX_RDY);
  assign tx_ready_o        = (tx_state_q == TX_RDY);
  assign rx_analogreset_o  = (rx_state_q == RX_ANA);
  assign rx_digitalreset_o = (rx_state_q != RX_RDY);
  assign rx_ready_o        = (rx_state_q == RX_RDY);

endmodule

// File: tb/tb_gx_rst_ctrl.sv
// Bench for gx_rst_ctrl: directed sequence timing plus randomized status noise
// checked every cycle against a phase/timer reference model.
module tb_gx_rst_ctrl;

  localparam int HOLD = 10;
  localparam int WAIT = 4;
  localparam int LTD  = 5;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst;
  logic pll_locked_i, tx_cal_busy_i, rx_cal_busy_i, rx_is_lockedtodata_i;
  logic tx_analogreset_o, tx_digitalreset_o, rx_analogreset_o, rx_digitalreset_o;
  logic tx_ready_o, rx_ready_o;

  always #5 clk = ~clk;

  gx_rst_ctrl #(
    .ANALOG_HOLD_CYC(HOLD), .DIGITAL_WAIT_CYC(WAIT),
    .LTD_STABLE_CYC(LTD), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst(rst),
    .pll_locked_i(pll_locked_i), .tx_cal_busy_i(tx_cal_busy_i),
    .rx_cal_busy_i(rx_cal_busy_i), .rx_is_lockedtodata_i(rx_is_lockedtodata_i),
    .tx_analogreset_o(tx_analogreset_o), .tx_digitalreset_o(tx_digitalreset_o),
    .rx_analogreset_o(rx_analogreset_o), .rx_digitalreset_o(rx_digitalreset_o),
    .tx_ready_o(tx_ready_o), .rx_ready_o(rx_ready_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int k;

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (edge %0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  // Reference model: each status pin reaches the sequencer SYNC edges late; each
  // direction is a phase plus a count of edges spent in it.
  // tx phase: 0 analog hold, 1 wait pll, 2 pll settle, 3 ready
  // rx phase: 0 analog hold, 1 wait stable lock, 2 ready
  bit h [4][SYNC];
  bit rv [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  int m_tx, m_rx, m_txt, m_rxt;

  task automatic model_edge();
    bit s [4];
    bit pin [4];
    pin[0] = pll_locked_i; pin[1] = tx_cal_busy_i;
    pin[2] = rx_cal_busy_i; pin[3] = rx_is_lockedtodata_i;
    if (rst) begin
      for (int i = 0; i < 4; i++) for (int j = 0; j < SYNC; j++) h[i][j] = rv[i];
      m_tx = 0; m_rx = 0; m_txt = 0; m_rxt = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        s[i] = h[i][SYNC-1];
        for (int j = SYNC-1; j > 0; j--) h[i][j] = h[i][j-1];
        h[i][0] = pin[i];
      end
      if (m_tx != 0 && s[1]) begin m_tx = 0; m_txt = 0; end
      else case (m_tx)
        0: if (m_txt + 1 >= HOLD && !s[1]) begin m_tx = 1; m_txt = 0; end else m_txt++;
        1: if (s[0]) begin m_tx = 2; m_txt = 0; end
        2: if (!s[0]) begin m_tx = 1; m_txt = 0; end
           else if (m_txt + 1 == WAIT) begin m_tx = 3; m_txt = 0; end
           else m_txt++;
        default: if (!s[0]) begin m_tx = 1; m_txt = 0; end
      endcase
      if (m_rx != 0 && s[2]) begin m_rx = 0; m_rxt = 0; end
      else case (m_rx)
        0: if (m_rxt + 1 >= HOLD && !s[2]) begin m_rx = 1; m_rxt = 0; end else m_rxt++;
        1: if (!s[3]) m_rxt = 0;
           else if (m_rxt + 1 == LTD) begin m_rx = 2; m_rxt = 0; end
           else m_rxt++;
        default: if (!s[3]) begin m_rx = 1; m_rxt = 0; end
      endcase
    end
  endtask

  function automatic logic [5:0] model_out();
    return {m_tx == 0, m_tx != 3, m_rx == 0, m_rx != 2, m_tx == 3, m_rx == 2};
  endfunction

  // Inputs are stable between negedges, so the model sees what the next posedge samples.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    k++;
    chk(tag, {tx_analogreset_o, tx_digitalreset_o, rx_analogreset_o, rx_digitalreset_o,
              tx_ready_o, rx_ready_o}, model_out());
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b1;
    for (int i = 0; i < cyc; i++) step("reset");
    rst = 1'b0;
    k = 0;
  endtask

  initial begin
    k = 0;
    rst = 1'b1;
    pll_locked_i = 1'b1; tx_cal_busy_i = 1'b0; rx_cal_busy_i = 1'b0; rx_is_lockedtodata_i = 1'b1;
    do_reset(3);

    // Power-up with healthy status.
    for (int n = 0; n < 20; n++) begin
      step("powerup");
      if (k == 9)  chk("pu_tx_ana_e9", tx_analogreset_o, 1'b1);
      if (k == 10) chk("pu_tx_ana_e10", tx_analogreset_o, 1'b0);
      if (k == 10) chk("pu_rx_ana_e10", rx_analogreset_o, 1'b0);
      if (k == 14) chk("pu_tx_dig_e14", tx_digitalreset_o, 1'b1);
      if (k == 15) chk("pu_tx_dig_e15", tx_digitalreset_o, 1'b0);
      if (k == 15) chk("pu_tx_rdy_e15", tx_ready_o, 1'b1);
      if (k == 14) chk("pu_rx_dig_e14", rx_digitalreset_o, 1'b1);
      if (k == 15) chk("pu_rx_dig_e15", rx_digitalreset_o, 1'b0);
    end

    // TX calibration stall until edge 30.
    tx_cal_busy_i = 1'b1;
    do_reset(2);
    for (int n = 0; n < 45; n++) begin
      step("calstall");
      if (k == 30) tx_cal_busy_i = 1'b0;
      if (k == 32) chk("cal_tx_ana_e32", tx_analogreset_o, 1'b1);
      if (k == 33) chk("cal_tx_ana_e33", tx_analogreset_o, 1'b0);
      if (k == 15) chk("cal_rx_rdy_e15", rx_ready_o, 1'b1);
    end

    // One-cycle PLL loss while ready.
    k = 0;
    pll_locked_i = 1'b0;
    step("pllloss");
    pll_locked_i = 1'b1;
    for (int n = 0; n < 12; n++) begin
      step("pllloss");
      if (k == 2) chk("pll_rdy_e2", tx_ready_o, 1'b1);
      if (k == 3) chk("pll_resets_e3", {tx_analogreset_o, tx_digitalreset_o, tx_ready_o}, 6'b010);
      if (k == 7) chk("pll_rdy_e7", tx_ready_o, 1'b0);
      if (k == 8) chk("pll_rdy_e8", tx_ready_o, 1'b1);
    end

    // RX recalibration from ready, with simultaneous loss of lock.
    k = 0;
    rx_cal_busy_i = 1'b1; rx_is_lockedtodata_i = 1'b0;
    step("recal");
    rx_cal_busy_i = 1'b0; rx_is_lockedtodata_i = 1'b1;
    for (int n = 0; n < 22; n++) begin
      step("recal");
      if (k == 2)  chk("recal_ana_e2", rx_analogreset_o, 1'b0);
      if (k == 3)  chk("recal_resets_e3", {rx_analogreset_o, rx_digitalreset_o}, 6'b11);
      if (k == 12) chk("recal_ana_e12", rx_analogreset_o, 1'b1);
      if (k == 13) chk("recal_ana_e13", rx_analogreset_o, 1'b0);
      if (k == 17) chk("recal_rdy_e17", rx_ready_o, 1'b0);
      if (k == 18) chk("recal_rdy_e18", rx_ready_o, 1'b1);
    end

    // rst asserted while TX is in its PLL settle window.
    do_reset(2);
    for (int n = 0; n < 30; n++) begin
      if (k == 12) rst = 1'b1;
      if (k == 13) rst = 1'b0;
      step("midrst");
      if (k == 13) chk("midrst_outs", {tx_analogreset_o, tx_digitalreset_o, rx_analogreset_o,
                                       rx_digitalreset_o, tx_ready_o, rx_ready_o}, 6'b111100);
      if (k == 22) chk("midrst_ana_e22", tx_analogreset_o, 1'b1);
      if (k == 23) chk("midrst_ana_e23", tx_analogreset_o, 1'b0);
    end

    // Random status noise in segments of varying severity.
    for (int seg = 0; seg < 10; seg++) begin
      int noise;
      noise = $urandom_range(0, 3);
      for (int n = 0; n < 300; n++) begin
        rst                  = ($urandom_range(0, 399) == 0);
        pll_locked_i         = !(noise > 0 && $urandom_range(0, 99) < 2 * noise);
        tx_cal_busy_i        = (noise > 1 && $urandom_range(0, 99) < noise);
        rx_cal_busy_i        = (noise > 1 && $urandom_range(0, 99) < noise);
        rx_is_lockedtodata_i = !(noise > 0 && $urandom_range(0, 99) < 3 * noise);
        step("random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
